// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types, opcodes and helpers for the ALU issue controller.
// Reservation-station entry layout and CDB operand wake-up live here.
package alu_issue_ctrl_pkg;

    typedef logic [31:0] WORD_TP;
    typedef logic [3:0]  ROB_IDX_TP;
    typedef logic [5:0]  INST_OPT_TP;

    localparam WORD_TP ZERO_WORD   = '0;
    localparam logic   TRUE        = 1'b1;
    localparam logic   FALSE       = 1'b0;
    localparam int     RS_SIZE_DEF = 8;

    localparam INST_OPT_TP OPT_NOP = 6'd0;
    localparam INST_OPT_TP OPT_ADD = 6'd1;
    localparam INST_OPT_TP OPT_SUB = 6'd2;
    localparam INST_OPT_TP OPT_AND = 6'd3;
    localparam INST_OPT_TP OPT_XOR = 6'd4;

    typedef struct packed {
        logic       busy;
        INST_OPT_TP opt;
        WORD_TP     val1;
        WORD_TP     val2;
        ROB_IDX_TP  dep1;
        ROB_IDX_TP  dep2;
        WORD_TP     imm;
        ROB_IDX_TP  rob_idx;
    } rs_entry_t;

    typedef struct packed {
        WORD_TP    val;
        ROB_IDX_TP dep;
    } opnd_t;

    // rob index 0 means "no producer", so src 0 never wakes anything
    function automatic opnd_t wake(
        input opnd_t     o,
        input logic      av,
        input ROB_IDX_TP as,
        input WORD_TP    aval,
        input logic      lv,
        input ROB_IDX_TP ls,
        input WORD_TP    lval
    );
        opnd_t r;
        r = o;
        if (av && as != '0 && as == o.dep) begin
            r.val = aval;
            r.dep = '0;
        end else if (lv && ls != '0 && ls == o.dep) begin
            r.val = lval;
            r.dep = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_rs_pick.sv
// Lowest-set-bit priority encoder with a found flag.
// Used for both free-slot and ready-slot selection.
module rs_pick #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU reservation station: dispatch, CDB wake-up and in-order-by-slot issue.
// All outputs are registered; selection looks at registered state only.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       dsp_valid,
    input  INST_OPT_TP dsp_opt,
    input  WORD_TP     dsp_imm,
    input  ROB_IDX_TP  dsp_rob_idx,
    input  WORD_TP     dsp_val1,
    input  WORD_TP     dsp_val2,
    input  ROB_IDX_TP  dsp_dep1,
    input  ROB_IDX_TP  dsp_dep2,
    output logic       rs_full,
    input  logic       cdb_alu_valid,
    input  ROB_IDX_TP  cdb_alu_src,
    input  WORD_TP     cdb_alu_val,
    input  logic       cdb_lsu_valid,
    input  ROB_IDX_TP  cdb_lsu_src,
    input  WORD_TP     cdb_lsu_val,
    input  logic       rob_flush,
    output logic       alu_en,
    output logic       rs_valid,
    output INST_OPT_TP rs_opt,
    output WORD_TP     rs_val1,
    output WORD_TP     rs_val2,
    output WORD_TP     rs_imm,
    output ROB_IDX_TP  rs_rob_idx
);

    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CW = $clog2(RS_SIZE + 1);

    rs_entry_t  ent_q [RS_SIZE];
    rs_entry_t  ent_d [RS_SIZE];
    logic [CW-1:0] cnt_q, cnt_d;
    logic       full_q, full_d;
    logic       valid_q, valid_d;
    logic       en_q, en_d;
    INST_OPT_TP opt_q, opt_d;
    WORD_TP     v1_q, v1_d;
    WORD_TP     v2_q, v2_d;
    WORD_TP     imm_q, imm_d;
    ROB_IDX_TP  rob_q, rob_d;

    logic [RS_SIZE-1:0] free_vec, ready_vec;
    logic [IW-1:0]      free_idx, rdy_idx;
    logic               free_found, rdy_found;
    logic               do_disp, do_issue;
    opnd_t              o1, o2;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && ent_q[i].dep1 == '0
                           && ent_q[i].dep2 == '0;
        end
    end

    rs_pick #(.N(RS_SIZE), .IW(IW)) u_free_pick (
        .req_i   (free_vec),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    rs_pick #(.N(RS_SIZE), .IW(IW)) u_ready_pick (
        .req_i   (ready_vec),
        .idx_o   (rdy_idx),
        .found_o (rdy_found)
    );

    always_comb begin
        ent_d    = ent_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        valid_d  = valid_q;
        en_d     = en_q;
        opt_d    = opt_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        imm_d    = imm_q;
        rob_d    = rob_q;
        do_disp  = FALSE;
        do_issue = FALSE;
        o1       = '0;
        o2       = '0;
        if (rdy) begin
            if (rob_flush) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    ent_d[i].busy = FALSE;
                end
                cnt_d   = '0;
                full_d  = FALSE;
                valid_d = FALSE;
                en_d    = FALSE;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent_q[i].busy) begin
                        o1 = wake('{val: ent_q[i].val1, dep: ent_q[i].dep1},
                                  cdb_alu_valid, cdb_alu_src, cdb_alu_val,
                                  cdb_lsu_valid, cdb_lsu_src, cdb_lsu_val);
                        o2 = wake('{val: ent_q[i].val2, dep: ent_q[i].dep2},
                                  cdb_alu_valid, cdb_alu_src, cdb_alu_val,
                                  cdb_lsu_valid, cdb_lsu_src, cdb_lsu_val);
                        ent_d[i].val1 = o1.val;
                        ent_d[i].dep1 = o1.dep;
                        ent_d[i].val2 = o2.val;
                        ent_d[i].dep2 = o2.dep;
                    end
                end
                do_issue = rdy_found;
                valid_d  = rdy_found;
                en_d     = rdy_found;
                if (rdy_found) begin
                    opt_d = ent_q[rdy_idx].opt;
                    v1_d  = ent_q[rdy_idx].val1;
                    v2_d  = ent_q[rdy_idx].val2;
                    imm_d = ent_q[rdy_idx].imm;
                    rob_d = ent_q[rdy_idx].rob_idx;
                    ent_d[rdy_idx].busy = FALSE;
                end
                // the issuing slot is still busy here, so it is never reused
                if (dsp_valid && !full_q && free_found) begin
                    do_disp = TRUE;
                    o1 = wake('{val: dsp_val1, dep: dsp_dep1},
                              cdb_alu_valid, cdb_alu_src, cdb_alu_val,
                              cdb_lsu_valid, cdb_lsu_src, cdb_lsu_val);
                    o2 = wake('{val: dsp_val2, dep: dsp_dep2},
                              cdb_alu_valid, cdb_alu_src, cdb_alu_val,
                              cdb_lsu_valid, cdb_lsu_src, cdb_lsu_val);
                    ent_d[free_idx] = '{
                        busy:    TRUE,
                        opt:     dsp_opt,
                        val1:    o1.val,
                        val2:    o2.val,
                        dep1:    o1.dep,
                        dep2:    o2.dep,
                        imm:     dsp_imm,
                        rob_idx: dsp_rob_idx
                    };
                end
                cnt_d  = cnt_q + CW'(do_disp) - CW'(do_issue);
                full_d = (cnt_d == CW'(RS_SIZE));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q   <= '0;
            full_q  <= FALSE;
            valid_q <= FALSE;
            en_q    <= FALSE;
            opt_q   <= OPT_NOP;
            v1_q    <= ZERO_WORD;
            v2_q    <= ZERO_WORD;
            imm_q   <= ZERO_WORD;
            rob_q   <= '0;
        end else begin
            ent_q   <= ent_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            en_q    <= en_d;
            opt_q   <= opt_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            imm_q   <= imm_d;
            rob_q   <= rob_d;
        end
    end

    assign rs_full    = full_q;
    assign rs_valid   = valid_q;
    assign alu_en     = en_q;
    assign rs_opt     = opt_q;
    assign rs_val1    = v1_q;
    assign rs_val2    = v2_q;
    assign rs_imm     = imm_q;
    assign rs_rob_idx = rob_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table plus
// hand-written fill, flush, freeze and reset sequences.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       dsp_valid;
    logic [5:0] dsp_opt;
    logic [31:0] dsp_imm, dsp_val1, dsp_val2;
    logic [3:0] dsp_rob_idx, dsp_dep1, dsp_dep2;
    logic       rs_full;
    logic       cdb_alu_valid, cdb_lsu_valid;
    logic [3:0] cdb_alu_src, cdb_lsu_src;
    logic [31:0] cdb_alu_val, cdb_lsu_val;
    logic       rob_flush;
    logic       alu_en, rs_valid;
    logic [5:0] rs_opt;
    logic [31:0] rs_val1, rs_val2, rs_imm;
    logic [3:0] rs_rob_idx;

    int errors = 0;
    int checks = 0;

    alu_issue_ctrl #(.RS_SIZE(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .dsp_valid     (dsp_valid),
        .dsp_opt       (dsp_opt),
        .dsp_imm       (dsp_imm),
        .dsp_rob_idx   (dsp_rob_idx),
        .dsp_val1      (dsp_val1),
        .dsp_val2      (dsp_val2),
        .dsp_dep1      (dsp_dep1),
        .dsp_dep2      (dsp_dep2),
        .rs_full       (rs_full),
        .cdb_alu_valid (cdb_alu_valid),
        .cdb_alu_src   (cdb_alu_src),
        .cdb_alu_val   (cdb_alu_val),
        .cdb_lsu_valid (cdb_lsu_valid),
        .cdb_lsu_src   (cdb_lsu_src),
        .cdb_lsu_val   (cdb_lsu_val),
        .rob_flush     (rob_flush),
        .alu_en        (alu_en),
        .rs_valid      (rs_valid),
        .rs_opt        (rs_opt),
        .rs_val1       (rs_val1),
        .rs_val2       (rs_val2),
        .rs_imm        (rs_imm),
        .rs_rob_idx    (rs_rob_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [5:0]  opt;
        logic [31:0] v1, v2, imm;
        logic [3:0]  d1, d2, rob;
        logic        av;
        logic [3:0]  as;
        logic [31:0] aval;
        logic        lv;
        logic [3:0]  ls;
        logic [31:0] lval;
        logic        e_valid;
        logic [5:0]  e_opt;
        logic [3:0]  e_rob;
        logic [31:0] e_v1, e_v2, e_imm;
    } vec_t;

    localparam int NV = 18;
    vec_t tv [NV];

    function automatic vec_t mk(
        input logic dv, input logic [5:0] opt,
        input logic [31:0] v1, input logic [31:0] v2,
        input logic [3:0] d1, input logic [3:0] d2,
        input logic [31:0] imm, input logic [3:0] rob,
        input logic av, input logic [3:0] as, input logic [31:0] aval,
        input logic lv, input logic [3:0] ls, input logic [31:0] lval,
        input logic ev, input logic [5:0] eopt, input logic [3:0] erob,
        input logic [31:0] ev1, input logic [31:0] ev2,
        input logic [31:0] eimm
    );
        vec_t r;
        r.dv = dv; r.opt = opt; r.v1 = v1; r.v2 = v2;
        r.d1 = d1; r.d2 = d2; r.imm = imm; r.rob = rob;
        r.av = av; r.as = as; r.aval = aval;
        r.lv = lv; r.ls = ls; r.lval = lval;
        r.e_valid = ev; r.e_opt = eopt; r.e_rob = erob;
        r.e_v1 = ev1; r.e_v2 = ev2; r.e_imm = eimm;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev,
                           input logic [5:0] eopt, input logic [3:0] erob,
                           input logic [31:0] ev1, input logic [31:0] ev2,
                           input logic [31:0] eimm, input logic efull);
        chk({tag, ".valid"}, 32'(rs_valid), 32'(ev));
        chk({tag, ".alu_en"}, 32'(alu_en), 32'(ev));
        chk({tag, ".opt"}, 32'(rs_opt), 32'(eopt));
        chk({tag, ".rob"}, 32'(rs_rob_idx), 32'(erob));
        chk({tag, ".val1"}, rs_val1, ev1);
        chk({tag, ".val2"}, rs_val2, ev2);
        chk({tag, ".imm"}, rs_imm, eimm);
        chk({tag, ".full"}, 32'(rs_full), 32'(efull));
    endtask

    task automatic idle();
        rdy = 1'b1; rob_flush = 1'b0;
        dsp_valid = 1'b0; dsp_opt = '0; dsp_imm = '0; dsp_rob_idx = '0;
        dsp_val1 = '0; dsp_val2 = '0; dsp_dep1 = '0; dsp_dep2 = '0;
        cdb_alu_valid = 1'b0; cdb_alu_src = '0; cdb_alu_val = '0;
        cdb_lsu_valid = 1'b0; cdb_lsu_src = '0; cdb_lsu_val = '0;
    endtask

    task automatic drv_disp(input logic [5:0] opt, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] rob);
        dsp_valid = 1'b1; dsp_opt = opt; dsp_imm = '0;
        dsp_val1 = v1; dsp_val2 = v2;
        dsp_dep1 = d1; dsp_dep2 = d2; dsp_rob_idx = rob;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = mk(1, OPT_ADD, 5, 7, 0, 0, 32'h100, 3,
                    0, 0, 0, 0, 0, 0, 0, OPT_NOP, 0, 0, 0, 0);
        tv[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 1, OPT_ADD, 3, 5, 7, 32'h100);
        tv[2]  = mk(1, OPT_SUB, 0, 2, 4, 0, 0, 5,
                    0, 0, 0, 0, 0, 0, 0, OPT_ADD, 3, 5, 7, 32'h100);
        tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    1, 4, 32'h10, 0, 0, 0, 0, OPT_ADD, 3, 5, 7, 32'h100);
        tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 1, OPT_SUB, 5, 32'h10, 2, 0);
        tv[5]  = mk(1, OPT_AND, 1, 0, 0, 6, 0, 7,
                    0, 0, 0, 1, 6, 32'hAB, 0, OPT_SUB, 5, 32'h10, 2, 0);
        tv[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 1, OPT_AND, 7, 1, 32'hAB, 0);
        tv[7]  = mk(1, OPT_XOR, 32'h11, 32'h22, 0, 0, 0, 8,
                    1, 0, 32'hDEAD, 0, 0, 0, 0, OPT_AND, 7, 1, 32'hAB, 0);
        tv[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 1, OPT_XOR, 8, 32'h11, 32'h22, 0);
        tv[9]  = mk(1, OPT_ADD, 0, 1, 9, 0, 0, 1,
                    0, 0, 0, 0, 0, 0, 0, OPT_XOR, 8, 32'h11, 32'h22, 0);
        tv[10] = mk(1, OPT_ADD, 0, 2, 9, 0, 0, 2,
                    0, 0, 0, 0, 0, 0, 0, OPT_XOR, 8, 32'h11, 32'h22, 0);
        tv[11] = mk(1, OPT_ADD, 0, 3, 9, 0, 0, 3,
                    0, 0, 0, 0, 0, 0, 0, OPT_XOR, 8, 32'h11, 32'h22, 0);
        tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    1, 8, 32'h77, 0, 0, 0, 0, OPT_XOR, 8, 32'h11, 32'h22, 0);
        tv[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 1, 9, 32'h99, 0, OPT_XOR, 8, 32'h11, 32'h22, 0);
        tv[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 1, OPT_ADD, 1, 32'h99, 1, 0);
        tv[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 1, OPT_ADD, 2, 32'h99, 2, 0);
        tv[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 1, OPT_ADD, 3, 32'h99, 3, 0);
        tv[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, OPT_ADD, 3, 32'h99, 3, 0);

        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, OPT_NOP, 0, 0, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            idle();
            dsp_valid = tv[i].dv; dsp_opt = tv[i].opt;
            dsp_val1 = tv[i].v1; dsp_val2 = tv[i].v2;
            dsp_dep1 = tv[i].d1; dsp_dep2 = tv[i].d2;
            dsp_imm = tv[i].imm; dsp_rob_idx = tv[i].rob;
            cdb_alu_valid = tv[i].av; cdb_alu_src = tv[i].as;
            cdb_alu_val = tv[i].aval;
            cdb_lsu_valid = tv[i].lv; cdb_lsu_src = tv[i].ls;
            cdb_lsu_val = tv[i].lval;
            step();
            chk_out($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_opt,
                    tv[i].e_rob, tv[i].e_v1, tv[i].e_v2, tv[i].e_imm, 0);
        end

        for (int k = 0; k < 8; k++) begin
            idle();
            drv_disp(OPT_ADD, 0, 32'(k), 4'(k + 1), 0, 4'(k + 1));
            step();
            chk($sformatf("fill%0d.full", k), 32'(rs_full),
                (k == 7) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d.valid", k), 32'(rs_valid), 0);
        end
        idle();
        drv_disp(OPT_XOR, 9, 0, 0, 0, 9);
        step();
        chk("ninth.full", 32'(rs_full), 1);
        chk("ninth.valid", 32'(rs_valid), 0);
        idle();
        cdb_alu_valid = 1; cdb_alu_src = 1; cdb_alu_val = 32'h55;
        step();
        chk("wake.full", 32'(rs_full), 1);
        chk("wake.valid", 32'(rs_valid), 0);
        idle();
        drv_disp(OPT_XOR, 12, 0, 0, 0, 12);
        step();
        chk_out("issue_full", 1, OPT_ADD, 1, 32'h55, 0, 0, 0);
        idle();
        step();
        chk("drop12.valid", 32'(rs_valid), 0);
        idle();
        drv_disp(OPT_ADD, 32'h13, 0, 0, 0, 13);
        step();
        chk("refill.full", 32'(rs_full), 1);
        idle();
        step();
        chk_out("refill_issue", 1, OPT_ADD, 13, 32'h13, 0, 0, 0);

        idle();
        rob_flush = 1;
        step();
        chk("flush0.full", 32'(rs_full), 0);
        for (int k = 0; k < 4; k++) begin
            idle();
            drv_disp(OPT_ADD, 0, 0, 11, 0, 4'(k + 1));
            step();
        end
        idle();
        drv_disp(OPT_ADD, 5, 5, 0, 0, 5);
        step();
        chk("pre_flush.valid", 32'(rs_valid), 0);
        idle();
        rob_flush = 1;
        drv_disp(OPT_ADD, 32'h14, 0, 0, 0, 14);
        step();
        chk("flush.valid", 32'(rs_valid), 0);
        chk("flush.full", 32'(rs_full), 0);
        for (int k = 0; k < 3; k++) begin
            idle();
            cdb_alu_valid = (k == 0); cdb_alu_src = 11;
            cdb_alu_val = 32'h66;
            step();
            chk($sformatf("post_flush%0d.valid", k), 32'(rs_valid), 0);
        end
        for (int k = 0; k < 8; k++) begin
            idle();
            drv_disp(OPT_ADD, 0, 0, 12, 0, 4'(k + 1));
            step();
            if (k >= 6)
                chk($sformatf("recount%0d.full", k), 32'(rs_full),
                    (k == 7) ? 32'd1 : 32'd0);
        end
        idle();
        rob_flush = 1;
        step();
        chk("flush2.full", 32'(rs_full), 0);

        idle();
        drv_disp(OPT_ADD, 32'h1234, 0, 0, 0, 15);
        step();
        idle();
        drv_disp(OPT_SUB, 32'h4321, 0, 0, 0, 14);
        step();
        chk_out("pre_freeze", 1, OPT_ADD, 15, 32'h1234, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            idle();
            rdy = 0; rob_flush = 1;
            drv_disp(OPT_XOR, 32'h66, 0, 0, 0, 6);
            cdb_lsu_valid = 1; cdb_lsu_src = 14; cdb_lsu_val = 32'hBAD;
            step();
            chk_out($sformatf("freeze%0d", k), 1, OPT_ADD, 15,
                    32'h1234, 0, 0, 0);
        end
        idle();
        step();
        chk_out("thaw", 1, OPT_SUB, 14, 32'h4321, 0, 0, 0);
        idle();
        step();
        chk_out("thaw_idle", 0, OPT_SUB, 14, 32'h4321, 0, 0, 0);

        idle();
        drv_disp(OPT_ADD, 32'h99, 0, 0, 0, 9);
        step();
        idle();
        #2 rst = 1'b0;
        #1 chk_out("async_rst", 0, OPT_NOP, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        step();
        chk_out("post_rst", 0, OPT_NOP, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
